// File: rtl/fb_swap_controller.sv
`default_nettype none
// ============================================================================
// Module      : fb_swap_controller
// Description : Ping-pong frame-buffer controller with tear-free swap on the
//               display frame-end. Optional statistics: FB_SWAP_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_swap_controller #(
   parameter int SCREEN_WIDTH       = 320,
   parameter int SCREEN_HEIGHT      = 180,
   parameter int MIN_DISPLAY_FRAMES = 1
) (
   input  logic        pixel_clk_in,
   input  logic        rst_n_in,
   input  logic        ray_valid_in,
   input  logic [15:0] ray_address_in,
   input  logic [15:0] ray_pixel_in,
   input  logic        ray_last_pixel_in,
   input  logic        display_frame_end_in,
   output logic [1:0]  fb_ready_to_switch_out,
   output logic [1:0]  fb_wea_out,
   output logic [15:0] fb_addr_out,
   output logic [15:0] fb_data_out,
   output logic        display_sel_out,
   output logic        overrun_err_out,
   output logic [15:0] swap_count_out,
   output logic [15:0] stall_frames_out
);

   typedef enum logic [1:0] {
      ST_RENDER    = 2'd0,
      ST_WAIT_SWAP = 2'd1,
      ST_SWAP      = 2'd2
   } state_t;

   localparam logic [31:0] C_NUM_PIXELS = 32'(SCREEN_WIDTH * SCREEN_HEIGHT);
   localparam logic [4:0]  C_MIN_FRAMES = 5'(MIN_DISPLAY_FRAMES);

   // Reset asserts asynchronously but releases on a clock edge.
   logic [1:0] rst_sync_q;
   logic [1:0] rst_sync_d;
   logic       rst_n;

   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   assign rst_n = rst_sync_q[1];

   state_t      state_q, state_d;
   logic        write_sel_q, write_sel_d;
   logic [3:0]  frames_q, frames_d;
   logic [1:0]  wea_q, wea_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic        err_q, err_d;
   logic        in_range;
   logic        swap_ok;
   logic        rdy;

   assign in_range = ({16'd0, ray_address_in} < C_NUM_PIXELS);
   assign swap_ok  = (({1'b0, frames_q} + 5'd1) >= C_MIN_FRAMES);
   // Masking with the last pixel keeps the grant from being sampled stale.
   assign rdy      = (state_q == ST_RENDER) && !ray_last_pixel_in;

   always_comb begin
      state_d     = state_q;
      write_sel_d = write_sel_q;
      frames_d    = frames_q;
      wea_d       = 2'b00;
      addr_d      = addr_q;
      data_d      = data_q;
      err_d       = err_q;

      if (display_frame_end_in && (frames_q != 4'hF)) begin
         frames_d = frames_q + 4'd1;
      end

      case (state_q)
         ST_RENDER: begin
            if (ray_valid_in && in_range) begin
               wea_d  = write_sel_q ? 2'b10 : 2'b01;
               addr_d = ray_address_in;
               data_d = ray_pixel_in;
            end
            if (ray_last_pixel_in) begin
               state_d = ST_WAIT_SWAP;
            end
         end
         ST_WAIT_SWAP: begin
            if (ray_valid_in || ray_last_pixel_in) begin
               err_d = 1'b1;
            end
            if (display_frame_end_in && swap_ok) begin
               write_sel_d = ~write_sel_q;
               frames_d    = 4'd0;
               state_d     = ST_SWAP;
            end
         end
         ST_SWAP: begin
            if (ray_valid_in || ray_last_pixel_in) begin
               err_d = 1'b1;
            end
            state_d = ST_RENDER;
         end
         default: begin
            state_d = ST_RENDER;
         end
      endcase
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RENDER;
         write_sel_q <= 1'b0;
         frames_q    <= 4'd0;
         wea_q       <= 2'b00;
         addr_q      <= 16'd0;
         data_q      <= 16'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         write_sel_q <= write_sel_d;
         frames_q    <= frames_d;
         wea_q       <= wea_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         err_q       <= err_d;
      end
   end

   assign fb_ready_to_switch_out = {rdy, rdy};
   assign fb_wea_out             = wea_q;
   assign fb_addr_out            = addr_q;
   assign fb_data_out            = data_q;
   assign display_sel_out        = ~write_sel_q;
   assign overrun_err_out        = err_q;

`ifdef FB_SWAP_STATS_EN
   logic [15:0] swap_count_q, swap_count_d;
   logic [15:0] stall_q, stall_d;

   always_comb begin
      swap_count_d = swap_count_q;
      stall_d      = stall_q;
      if ((state_q == ST_WAIT_SWAP) && display_frame_end_in) begin
         if (swap_ok) begin
            swap_count_d = swap_count_q + 16'd1;
         end else begin
            stall_d = stall_q + 16'd1;
         end
      end
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n) begin
      if (!rst_n) begin
         swap_count_q <= 16'd0;
         stall_q      <= 16'd0;
      end else begin
         swap_count_q <= swap_count_d;
         stall_q      <= stall_d;
      end
   end

   assign swap_count_out   = swap_count_q;
   assign stall_frames_out = stall_q;
`else
   assign swap_count_out   = 16'd0;
   assign stall_frames_out = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_swap_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_swap_controller
// Description : Self-checking bench for fb_swap_controller; two instances
//               (minimum 1 and 3 display frames) share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_swap_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        v;
   logic [15:0] a;
   logic [15:0] p;
   logic        l;
   logic        f;

   logic [1:0]  rdy   [2];
   logic [1:0]  wea   [2];
   logic [15:0] addr  [2];
   logic [15:0] data  [2];
   logic        dsel  [2];
   logic        err   [2];
   logic [15:0] sc    [2];
   logic [15:0] sf    [2];

   always #5 clk = ~clk;

   fb_swap_controller #(.MIN_DISPLAY_FRAMES(1)) u_dut_min1 (
      .pixel_clk_in(clk), .rst_n_in(rst_n), .ray_valid_in(v), .ray_address_in(a),
      .ray_pixel_in(p), .ray_last_pixel_in(l), .display_frame_end_in(f),
      .fb_ready_to_switch_out(rdy[0]), .fb_wea_out(wea[0]), .fb_addr_out(addr[0]),
      .fb_data_out(data[0]), .display_sel_out(dsel[0]), .overrun_err_out(err[0]),
      .swap_count_out(sc[0]), .stall_frames_out(sf[0])
   );

   fb_swap_controller #(.MIN_DISPLAY_FRAMES(3)) u_dut_min3 (
      .pixel_clk_in(clk), .rst_n_in(rst_n), .ray_valid_in(v), .ray_address_in(a),
      .ray_pixel_in(p), .ray_last_pixel_in(l), .display_frame_end_in(f),
      .fb_ready_to_switch_out(rdy[1]), .fb_wea_out(wea[1]), .fb_addr_out(addr[1]),
      .fb_data_out(data[1]), .display_sel_out(dsel[1]), .overrun_err_out(err[1]),
      .swap_count_out(sc[1]), .stall_frames_out(sf[1])
   );

   // Reference model: frame bookkeeping per instance.
   int          mins [2] = '{1, 3};
   bit          m_done   [2];   // last pixel seen, waiting for a swap
   bit          m_settle [2];   // cycle right after a swap
   bit          m_back   [2];   // buffer being written
   bit          m_err    [2];
   int          m_shown  [2];
   logic [1:0]  m_wea    [2];
   logic [15:0] m_addr   [2];
   logic [15:0] m_data   [2];
   logic [15:0] m_swaps  [2];
   logic [15:0] m_stalls [2];

   int n_cmp;
   int n_fail;

   task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s [min%0d]: observed %0h expected %0h", tag, mins[k], obs, exp);
      end
   endtask

   function automatic bit m_render(input int k);
      return !m_done[k] && !m_settle[k];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_done[k] = 0; m_settle[k] = 0; m_back[k] = 0; m_err[k] = 0; m_shown[k] = 0;
         m_wea[k] = 2'b00; m_addr[k] = 16'd0; m_data[k] = 16'd0;
         m_swaps[k] = 16'd0; m_stalls[k] = 16'd0;
      end
   endtask

   task automatic model_edge(input int k);
      bit rend;
      bit swapped;
      rend    = m_render(k);
      swapped = 0;
      m_settle[k] = 0;
      if (v && rend && (a < 16'd57600)) begin
         m_wea[k]  = m_back[k] ? 2'b10 : 2'b01;
         m_addr[k] = a;
         m_data[k] = p;
      end else begin
         m_wea[k] = 2'b00;
      end
      if ((v || l) && !rend) m_err[k] = 1;
      if (rend && l) begin
         m_done[k] = 1;
      end else if (m_done[k] && f) begin
         if (m_shown[k] + 1 >= mins[k]) begin
            swapped     = 1;
            m_back[k]   = !m_back[k];
            m_done[k]   = 0;
            m_settle[k] = 1;
            m_swaps[k]  = m_swaps[k] + 16'd1;
         end else begin
            m_stalls[k] = m_stalls[k] + 16'd1;
         end
      end
      if (f) m_shown[k] = swapped ? 0 : ((m_shown[k] < 15) ? m_shown[k] + 1 : 15);
   endtask

   task automatic check_grant(input bit il);
      for (int k = 0; k < 2; k++)
         chk("grant", k, 16'(rdy[k]), (m_render(k) && !il) ? 16'h3 : 16'h0);
   endtask

   task automatic check_regs();
      for (int k = 0; k < 2; k++) begin
         chk("wea", k, 16'(wea[k]), 16'(m_wea[k]));
         chk("addr", k, addr[k], m_addr[k]);
         chk("data", k, data[k], m_data[k]);
         chk("display_sel", k, 16'(dsel[k]), 16'(!m_back[k]));
         chk("overrun", k, 16'(err[k]), 16'(m_err[k]));
`ifdef FB_SWAP_STATS_EN
         chk("swap_count", k, sc[k], m_swaps[k]);
         chk("stall_frames", k, sf[k], m_stalls[k]);
`else
         chk("swap_count", k, sc[k], 16'd0);
         chk("stall_frames", k, sf[k], 16'd0);
`endif
      end
   endtask

   // Entered and left at posedge+1.
   task automatic cyc(input bit iv, input logic [15:0] ia, input logic [15:0] ip,
                      input bit il, input bit ifr);
      v = iv; a = ia; p = ip; l = il; f = ifr;
      #1;
      check_grant(il);
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_edge(k);
      #1;
      check_regs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      v = 0; a = 0; p = 0; l = 0; f = 0;
      model_reset();
      #1;
      check_regs();
      check_grant(1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_regs();
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      rst_n = 1'b0;
      v = 0; a = 0; p = 0; l = 0; f = 0;
      #2;
      do_reset();

      // Out-of-range address in RENDER is dropped silently.
      cyc(1'b1, 16'd57600, 16'hBEEF, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) chk("oor_no_err", k, 16'(err[k]), 16'd0);

      // Full frame sweep, last pixel on the final write.
      for (int i = 0; i < 57600; i++)
         cyc(1'b1, 16'(i), 16'($urandom), i == 57599, 1'b0);
      for (int i = 0; i < 9; i++) cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
      chk("swap_at_fe", 0, 16'(dsel[0]), 16'd0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 16'(i), 16'($urandom), 1'b0, 1'b0);

      // Randomized traffic with occasional protocol violations.
      for (int i = 0; i < 2500; i++) begin
         bit iv, il, ifr;
         ifr = ($urandom_range(0, 7) == 0);
         iv  = ($urandom_range(0, 3) != 0) && (m_render(0) || ($urandom_range(0, 40) == 0));
         il  = m_render(0) && ($urandom_range(0, 15) == 0);
         cyc(iv, 16'($urandom_range(0, 57700)), 16'($urandom), il, ifr);
      end

      // Last pixel and frame-end together: no swap at that edge.
      do_reset();
      cyc(1'b1, 16'd5, 16'h1234, 1'b0, 1'b0);
      cyc(1'b1, 16'd6, 16'h5678, 1'b1, 1'b1);
      chk("no_swap_same_edge", 0, 16'(dsel[0]), 16'd1);
      for (int i = 0; i < 4; i++) cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
      chk("swap_next_fe", 0, 16'(dsel[0]), 16'd0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);

      // Reset asserted while waiting for a swap.
      for (int i = 0; i < 3; i++) cyc(1'b1, 16'(i + 100), 16'($urandom), i == 2, 1'b0);
      cyc(1'b1, 16'd200, 16'd0, 1'b0, 1'b0);
      v = 0; a = 0; p = 0; l = 0; f = 0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_display_sel", k, 16'(dsel[k]), 16'd1);
         chk("rst_grant", k, 16'(rdy[k]), 16'h3);
         chk("rst_overrun", k, 16'(err[k]), 16'd0);
      end
      do_reset();
      cyc(1'b1, 16'd42, 16'hA5A5, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
